dcfeb_cfg_chain_ctrl: RTL and testbench

//  Sequencer that loads a daisy-chained string of user_wr_reg write registers from a parallel word.

---
 rtl/dcfeb_cfg_pkg.sv | 18 +
 rtl/cfg_bit_counter.sv | 28 ++
 rtl/dcfeb_cfg_chain_ctrl.sv | 152 +++++++++++++++
 tb/tb_dcfeb_cfg_chain_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dcfeb_cfg_pkg.sv
// Shared definitions for the DCFEB configuration-chain loader: FSM state codes,
// default sizing and the LEN legality test.
package dcfeb_cfg_pkg;

  localparam int MAXW_DEF = 64;
  localparam int LENW_DEF = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_UPD   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // A load must move at least one bit and never more than the chain holds.
  function automatic logic len_legal(input int unsigned len, input int unsigned maxw);
    return (len != 0) && (len <= maxw);
  endfunction

endpackage

// File: rtl/cfg_bit_counter.sv
// Loadable down-counter tracking the remaining SHIFT cycles; saturates at zero.
module cfg_bit_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dcfeb_cfg_chain_ctrl.sv
// Serial loader for the DCFEB user_wr_reg chain: shifts a parallel word LSB-first,
// then strobes UPDATE. Optional TDO capture into RD_DATA via DCFEB_CFG_CHAIN_READBACK_EN.
module dcfeb_cfg_chain_ctrl
  import dcfeb_cfg_pkg::*;
#(
  parameter int MAXW = MAXW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            TCK,
  input  logic            RST,
  input  logic            START,
  input  logic            ABORT,
  input  logic [LENW-1:0] LEN,
  input  logic [MAXW-1:0] WR_DATA,
  input  logic            TDO_IN,
  output logic            SEL,
  output logic            FSEL,
  output logic            SHIFT,
  output logic            UPDATE,
  output logic            TDI_OUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [MAXW-1:0] RD_DATA
);

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic            accept;
  logic            dec;
  logic            err_nx;
  logic            abort_hit;
  logic            cnt_zero;
  logic [MAXW-1:0] shreg;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    dec       = 1'b0;
    err_nx    = 1'b0;
    abort_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (len_legal(32'(LEN), 32'(MAXW))) begin
            accept   = 1'b1;
            state_nx = ST_SHIFT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // ABORT wins over the final bit so no UPDATE can follow a cancelled load.
        if (ABORT) begin
          abort_hit = 1'b1;
          state_nx  = ST_IDLE;
        end else if (cnt_zero) begin
          state_nx = ST_UPD;
        end else begin
          dec = 1'b1;
        end
      end
      ST_UPD: begin
        abort_hit = ABORT;
        state_nx  = ABORT ? ST_IDLE : ST_FIN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  cfg_bit_counter #(
    .W (LENW)
  ) u_cnt (
    .clk      (TCK),
    .rst      (RST),
    .clear    (abort_hit),
    .load     (accept),
    .dec      (dec),
    .load_val (LEN - LENW'(1)),
    .zero     (cnt_zero)
  );

  // Control and strobes: registered from the next state so outputs track the FSM.
  always_ff @(posedge TCK) begin
    if (RST) begin
      state   <= ST_IDLE;
      SEL     <= 1'b0;
      FSEL    <= 1'b0;
      SHIFT   <= 1'b0;
      UPDATE  <= 1'b0;
      TDI_OUT <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state  <= state_nx;
      SEL    <= (state_nx == ST_SHIFT) || (state_nx == ST_UPD);
      FSEL   <= (state_nx == ST_SHIFT) || (state_nx == ST_UPD);
      SHIFT  <= (state_nx == ST_SHIFT);
      UPDATE <= (state_nx == ST_UPD);
      BUSY   <= (state_nx != ST_IDLE);
      DONE   <= (state_nx == ST_FIN);
      ERR    <= err_nx;
      if (accept) begin
        TDI_OUT <= WR_DATA[0];
      end else if (dec) begin
        TDI_OUT <= shreg[0];
      end else begin
        TDI_OUT <= 1'b0;
      end
    end
  end

  // Data shifter: holds the bits still to be presented on TDI_OUT.
  always_ff @(posedge TCK) begin
    if (accept) begin
      shreg <= WR_DATA >> 1;
    end else if (dec) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef DCFEB_CFG_CHAIN_READBACK_EN
  logic [MAXW-1:0] rd_data;
  logic [MAXW-1:0] bit_mask;

  // Bit k of the return is sampled at the end of SHIFT cycle k.
  always_ff @(posedge TCK) begin
    if (RST || accept) begin
      rd_data <= '0;
    end else if ((state == ST_SHIFT) && TDO_IN) begin
      rd_data <= rd_data | bit_mask;
    end
  end

  always_ff @(posedge TCK) begin
    if (accept) begin
      bit_mask <= MAXW'(1);
    end else if (state == ST_SHIFT) begin
      bit_mask <= bit_mask << 1;
    end
  end

  assign RD_DATA = rd_data;
`else
  logic unused_tdo;
  assign unused_tdo = TDO_IN;
  assign RD_DATA    = '0;
`endif

endmodule

// File: tb/tb_dcfeb_cfg_chain_ctrl.sv
// Scoreboard bench for dcfeb_cfg_chain_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dcfeb_cfg_chain_ctrl;

  localparam int MAXW = 64;
  localparam int LENW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [LENW-1:0] len = '0;
  logic [MAXW-1:0] wr_data = '0;
  logic            tdo_in = 1'b0;
  logic            sel, fsel, shift, update, tdi_out, busy, done, err;
  logic [MAXW-1:0] rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  bit              exp_tdi[$];
  int              exp_upd[$];
  int              exp_done[$];
  int              exp_err[$];
  logic [MAXW-1:0] exp_rd[$];

  dcfeb_cfg_chain_ctrl #(.MAXW(MAXW), .LENW(LENW)) dut (
    .TCK     (clk),
    .RST     (rst),
    .START   (start),
    .ABORT   (abort),
    .LEN     (len),
    .WR_DATA (wr_data),
    .TDO_IN  (tdo_in),
    .SEL     (sel),
    .FSEL    (fsel),
    .SHIFT   (shift),
    .UPDATE  (update),
    .TDI_OUT (tdi_out),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err),
    .RD_DATA (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (shift) begin
        if (exp_tdi.size() == 0) check("unexpected_shift", 1, 0);
        else begin
          check("tdi_bit", tdi_out, exp_tdi.pop_front());
          check("sel_fsel_busy_in_shift", {sel, fsel, busy}, 3'b111);
        end
      end
      if (update) begin
        if (exp_upd.size() == 0) check("unexpected_update", 1, 0);
        else check("update_cycle", cyc, exp_upd.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else begin
          check("done_cycle", cyc, exp_done.pop_front());
          check("rd_data_at_done", rd_data, exp_rd.pop_front());
        end
      end
      if (err) begin
        if (exp_err.size() == 0) check("unexpected_err", 1, 0);
        else begin
          check("err_cycle", cyc, exp_err.pop_front());
          check("busy_shift_on_err", {busy, shift}, 2'b00);
        end
      end
    end
  end

  // Issue one START; queue nbits of TDI and, if a full load is expected, UPDATE/DONE.
  task automatic issue(input logic [LENW-1:0] l, input logic [MAXW-1:0] d,
                       input int nbits, input bit full, input logic [MAXW-1:0] rd_exp);
    int t;
    @(negedge clk);
    start = 1'b1;
    len = l;
    wr_data = d;
    t = cyc;
    for (int k = 0; k < nbits; k++) exp_tdi.push_back(d[k]);
    if (full) begin
      exp_upd.push_back(t + 1 + int'(l));
      exp_done.push_back(t + 2 + int'(l));
      exp_rd.push_back(rd_exp);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_bad(input logic [LENW-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len = l;
    exp_err.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_tdi.size() + exp_upd.size() + exp_done.size() + exp_err.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {sel, fsel, shift, update, tdi_out, busy, done, err}, 8'h00);
    check({name, "_rd"}, rd_data, '0);
  endtask

  logic [MAXW-1:0] rd5;
  bit tdo_seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  initial begin
`ifdef DCFEB_CFG_CHAIN_READBACK_EN
    rd5 = 64'h4D;
`else
    rd5 = 64'h0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    mon_en = 1'b1;

    // 16-bit load of 16'hA5C3: UPDATE at t+17, DONE at t+18.
    issue(7'd16, 64'hA5C3, 16, 1'b1, '0);
    wait_drain();

    // Illegal lengths.
    issue_bad(7'd0);
    issue_bad(7'd65);
    wait_drain();

    // ABORT during SHIFT cycle 3: four bits seen, no UPDATE/DONE.
    issue(7'd8, 64'h5B, 4, 1'b0, '0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_after_abort", {shift, busy, sel, update}, 4'b0000);
    repeat (3) @(negedge clk);
    issue(7'd5, 64'h16, 5, 1'b1, '0);
    wait_drain();

    // START while busy ignored; RST in the cycle before UPD kills UPDATE.
    issue(7'd8, 64'h96, 8, 1'b0, '0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    len = 7'd4;
    wr_data = 64'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("outputs_after_rst");
    wait_drain();

    // Readback of TDO pattern 1,0,1,1,0,0,1,0.
    issue(7'd8, 64'hC3, 8, 1'b1, rd5);
    for (int k = 0; k < 8; k++) begin
      tdo_in = tdo_seq[k];
      @(negedge clk);
    end
    tdo_in = 1'b0;
    wait_drain();

    // Full-width load of all ones.
    issue(7'd64, {MAXW{1'b1}}, 64, 1'b1, '0);
    wait_drain();

    check("tdi_queue_empty", exp_tdi.size(), 0);
    check("final_idle", {busy, shift, update, done}, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
